// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming SECDED encode sequencer.
package hamming_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LD_LO = 3'd1,
    S_LD_HI = 3'd2,
    S_WR_HI = 3'd3,
    S_WR_LO = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  // Bit positions inside the 16-bit code word; bit k holds Hamming position k.
  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int D1_POS = 3;
  localparam int P4_POS = 4;
  localparam int D2_POS = 5;
  localparam int P8_POS = 8;
  localparam int D5_POS = 9;

  localparam int DEF_NUM_MSG  = 15;
  localparam int DEF_SRC_BASE = 0;
  localparam int DEF_DST_BASE = 30;
  localparam int DEF_AW       = 8;

endpackage

// File: rtl/hamming_enc_seq_enc16.sv
// Combinational 11-bit message to 16-bit SECDED code word encoder.
module hamming_enc16
  import hamming_pkg::*;
(
  input  logic [10:0] msg,
  output logic [15:0] code
);

  logic [11:1] d;
  logic        p8;
  logic        p4;
  logic        p2;
  logic        p1;
  logic        p0;

  // Parity generation and placement of data and check bits into the code word.
  always_comb begin
    d  = msg;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;

    code            = 16'h0000;
    code[15:D5_POS] = d[11:5];
    code[P8_POS]    = p8;
    code[7:D2_POS]  = d[4:2];
    code[P4_POS]    = p4;
    code[D1_POS]    = d[1];
    code[P2_POS]    = p2;
    code[P1_POS]    = p1;
    code[P0_POS]    = p0;
  end

endmodule

// File: rtl/hamming_enc_seq.sv
// Memory-master sequencer: reads NUM_MSG messages, writes their SECDED encodings back.
module hamming_enc_seq
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = DEF_NUM_MSG,
  parameter int SRC_BASE = DEF_SRC_BASE,
  parameter int DST_BASE = DEF_DST_BASE,
  parameter int AW       = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data
);

  localparam logic [6:0] LAST_IDX = 7'(NUM_MSG - 1);

  state_t        state;
  state_t        state_next;
  logic [6:0]    idx;
  logic [6:0]    idx_next;
  logic          done_next;
  logic [7:0]    lo_reg;
  logic [2:0]    hi_reg;
  logic [15:0]   code;
  logic [AW-1:0] off;
  logic [AW-1:0] src_a;
  logic [AW-1:0] dst_a;

  hamming_enc16 u_enc (
    .msg  ({hi_reg, lo_reg}),
    .code (code)
  );

  // State, message index, done flag and captured source bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      idx    <= 7'd0;
      done   <= 1'b0;
      lo_reg <= 8'd0;
      hi_reg <= 3'd0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      done  <= done_next;
      if (state == S_LD_LO) lo_reg <= mem_rd_data;
      if (state == S_LD_HI) hi_reg <= mem_rd_data[2:0];
    end
  end

  // Next-state logic and memory-port drive; addresses wrap modulo 2^AW.
  always_comb begin
    state_next  = state;
    idx_next    = idx;
    done_next   = done;
    busy        = 1'b1;
    mem_addr    = {AW{1'b0}};
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'h00;
    off         = AW'({idx, 1'b0});
    src_a       = AW'(SRC_BASE) + off;
    dst_a       = AW'(DST_BASE) + off;

    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = S_LD_LO;
          idx_next   = 7'd0;
          done_next  = 1'b0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LD_LO: begin
        mem_addr   = src_a;
        state_next = S_LD_HI;
      end
      S_LD_HI: begin
        mem_addr   = src_a + AW'(1);
        state_next = S_WR_HI;
      end
      S_WR_HI: begin
        mem_wr_en   = 1'b1;
        mem_addr    = dst_a + AW'(1);
        mem_wr_data = code[15:8];
        state_next  = S_WR_LO;
      end
      S_WR_LO: begin
        mem_wr_en   = 1'b1;
        mem_addr    = dst_a;
        mem_wr_data = code[7:0];
        if (idx == LAST_IDX) begin
          state_next = S_FIN;
        end else begin
          idx_next   = idx + 7'd1;
          state_next = S_LD_LO;
        end
      end
      S_FIN: begin
        // done rises one cycle after entering FIN unless a new run is accepted.
        busy = 1'b0;
        if (start) begin
          state_next = S_LD_LO;
          idx_next   = 7'd0;
          done_next  = 1'b0;
        end else begin
          done_next = 1'b1;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
